// File: rtl/g10_pkg.sv
// Shared constants and types for the 10GBASE-R 32-bit receive gearbox.
// Sync headers are listed with bit 0 as the first bit on the wire.
package g10_pkg;

   localparam int BLOCK_W = 66;
   localparam int WORD_W  = 32;

   localparam logic [1:0] SH_DATA = 2'b10;
   localparam logic [1:0] SH_CTRL = 2'b01;

   typedef enum logic [1:0] {
      ST_UNLOCKED  = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } lock_state_t;

   function automatic logic sh_valid(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Block-lock state machine: qualifies sync headers, requests 1-bit slips
// until aligned, and drops lock when too many headers in a window are bad.
module block_lock_fsm
   import g10_pkg::*;
#(
   parameter int LOCK_CNT    = 64,
   parameter int WINDOW      = 64,
   parameter int BAD_HDR_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] hdr,
   input  logic       hdr_vld,
   input  logic       slip_done,
   output logic       lock,
   output logic       slip_req,
   output logic       hdr_err
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int HW = $clog2(WINDOW + 1);
   localparam int BW = $clog2(BAD_HDR_MAX + 1);

   localparam logic [GW-1:0] LOCK_LIM = GW'(LOCK_CNT);
   localparam logic [HW-1:0] WIN_LIM  = HW'(WINDOW);
   localparam logic [BW-1:0] BAD_LIM  = BW'(BAD_HDR_MAX);

   lock_state_t   r_state, w_state_nxt;
   logic [GW-1:0] r_good_cnt, w_good_nxt, w_good_inc;
   logic [HW-1:0] r_hdr_cnt, w_hdr_nxt, w_hdr_inc;
   logic [BW-1:0] r_bad_cnt, w_bad_nxt, w_bad_inc;
   logic          r_slip_seen, w_seen_nxt;
   logic          r_lock, w_lock_nxt;
   logic          r_slip_req, w_slip_nxt;
   logic          r_hdr_err;
   logic          w_hdr_ok;

   assign w_hdr_ok   = sh_valid(hdr);
   assign w_good_inc = r_good_cnt + GW'(1);
   assign w_hdr_inc  = r_hdr_cnt + HW'(1);
   assign w_bad_inc  = r_bad_cnt + BW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      w_hdr_nxt   = r_hdr_cnt;
      w_bad_nxt   = r_bad_cnt;
      w_seen_nxt  = r_slip_seen | slip_done;
      w_lock_nxt  = r_lock;
      w_slip_nxt  = 1'b0;
      case (r_state)
         ST_UNLOCKED: begin
            if (hdr_vld) begin
               if (!w_hdr_ok) begin
                  w_good_nxt  = '0;
                  w_slip_nxt  = 1'b1;
                  w_seen_nxt  = 1'b0;
                  w_state_nxt = ST_SLIP_WAIT;
               end else if (w_good_inc == LOCK_LIM) begin
                  w_good_nxt  = '0;
                  w_hdr_nxt   = '0;
                  w_bad_nxt   = '0;
                  w_lock_nxt  = 1'b1;
                  w_state_nxt = ST_LOCKED;
               end else begin
                  w_good_nxt = w_good_inc;
               end
            end
         end
         // The header after the slip lands still straddles the old alignment.
         ST_SLIP_WAIT: begin
            if (hdr_vld && r_slip_seen) begin
               w_seen_nxt  = 1'b0;
               w_good_nxt  = '0;
               w_state_nxt = ST_UNLOCKED;
            end
         end
         ST_LOCKED: begin
            if (hdr_vld) begin
               if (!w_hdr_ok && (w_bad_inc == BAD_LIM)) begin
                  w_hdr_nxt   = '0;
                  w_bad_nxt   = '0;
                  w_lock_nxt  = 1'b0;
                  w_slip_nxt  = 1'b1;
                  w_seen_nxt  = 1'b0;
                  w_state_nxt = ST_SLIP_WAIT;
               end else if (w_hdr_inc == WIN_LIM) begin
                  w_hdr_nxt = '0;
                  w_bad_nxt = '0;
               end else begin
                  w_hdr_nxt = w_hdr_inc;
                  if (!w_hdr_ok) w_bad_nxt = w_bad_inc;
               end
            end
         end
         default: begin
            w_lock_nxt  = 1'b0;
            w_state_nxt = ST_UNLOCKED;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_UNLOCKED;
         r_good_cnt  <= '0;
         r_hdr_cnt   <= '0;
         r_bad_cnt   <= '0;
         r_slip_seen <= 1'b0;
         r_lock      <= 1'b0;
         r_slip_req  <= 1'b0;
         r_hdr_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_good_cnt  <= w_good_nxt;
         r_hdr_cnt   <= w_hdr_nxt;
         r_bad_cnt   <= w_bad_nxt;
         r_slip_seen <= w_seen_nxt;
         r_lock      <= w_lock_nxt;
         r_slip_req  <= w_slip_nxt;
         r_hdr_err   <= hdr_vld & ~w_hdr_ok;
      end
   end

   assign lock     = r_lock;
   assign slip_req = r_slip_req;
   assign hdr_err  = r_hdr_err;

endmodule

// File: rtl/gearbox_rx_32b.sv
// 10GBASE-R receive gearbox: 32-bit line words in, 66b blocks out as an even
// half (header + bits 33:2) and an odd half (bits 65:34), with block lock.
module gearbox_rx_32b
   import g10_pkg::*;
#(
   parameter int LOCK_CNT    = 64,
   parameter int WINDOW      = 64,
   parameter int BAD_HDR_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic [1:0]  ctrl,
   output logic        dout_en,
   output logic        even,
   output logic        lock,
   output logic        hdr_err
);

   logic [BLOCK_W-1:0] r_buf;
   logic [6:0]         r_fill;
   logic               r_odd;
   logic               r_slip_pend;
   logic [31:0]        r_dout;
   logic [1:0]         r_ctrl;
   logic               r_dout_en;
   logic               r_even;

   logic [BLOCK_W-1:0] w_cat, w_adj, w_rest;
   logic [6:0]         w_avail, w_adj_avail, w_need;
   logic               w_slip_apply, w_emit, w_slip_req;

   // Bits above fill are always zero, so the new word can simply be OR-ed in.
   assign w_cat        = r_buf | ({{(BLOCK_W-WORD_W){1'b0}}, din} << r_fill);
   assign w_avail      = r_fill + 7'd32;
   assign w_slip_apply = r_slip_pend & ~r_odd;
   assign w_adj        = w_slip_apply ? (w_cat >> 1) : w_cat;
   assign w_adj_avail  = w_avail - {6'd0, w_slip_apply};
   assign w_need       = r_odd ? 7'd32 : 7'd34;
   assign w_emit       = (w_adj_avail >= w_need);
   assign w_rest       = r_odd ? (w_adj >> 32) : (w_adj >> 34);

   block_lock_fsm #(
      .LOCK_CNT    (LOCK_CNT),
      .WINDOW      (WINDOW),
      .BAD_HDR_MAX (BAD_HDR_MAX)
   ) u_lock (
      .clk       (clk),
      .rst       (rst),
      .hdr       (w_adj[1:0]),
      .hdr_vld   (w_emit & ~r_odd),
      .slip_done (w_slip_apply),
      .lock      (lock),
      .slip_req  (w_slip_req),
      .hdr_err   (hdr_err)
   );

   // NOTE: the bit buffer is reset along with fill so that a reset mid-block
   // cannot leak stale bits into the first block after realignment starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf       <= '0;
         r_fill      <= '0;
         r_odd       <= 1'b0;
         r_slip_pend <= 1'b0;
         r_dout      <= '0;
         r_ctrl      <= '0;
         r_dout_en   <= 1'b0;
         r_even      <= 1'b0;
      end else begin
         r_slip_pend <= (r_slip_pend & ~w_slip_apply) | w_slip_req;
         r_dout_en   <= w_emit;
         if (w_emit) begin
            r_buf  <= w_rest;
            r_fill <= w_adj_avail - w_need;
            r_odd  <= ~r_odd;
            r_even <= ~r_odd;
            if (r_odd) begin
               r_dout <= w_adj[31:0];
            end else begin
               r_dout <= w_adj[33:2];
               r_ctrl <= w_adj[1:0];
            end
         end else begin
            r_buf  <= w_adj;
            r_fill <= w_adj_avail;
         end
      end
   end

   assign dout    = r_dout;
   assign ctrl    = r_ctrl;
   assign dout_en = r_dout_en;
   assign even    = r_even;

endmodule
